// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM path: de-interleaves a beat stream (slot 0 marked by
// frame_start) into four channel registers that are published atomically per complete frame.
module tdm_demux4 #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] IN,
   input  logic             in_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] D,
   output logic [1:0]       Sel,
   output logic             frame_valid,
   output logic             sync_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             state_dbg
);

   // Input handshake: valid-only, no backpressure. A beat is any cycle with in_valid=1;
   // IN and frame_start are don't-care when in_valid=0 and every register holds.

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sel_d;
   logic [WIDTH-1:0] shadow_q [0:2];
   logic [WIDTH-1:0] shadow_d [0:2];
   logic [WIDTH-1:0] a_d, b_d, c_d, d_d;
   logic [CNT_W-1:0] cnt_d;
   logic             fv_d, se_d;

   assign state_dbg = state_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         Sel         <= 2'd0;
         shadow_q[0] <= '0;
         shadow_q[1] <= '0;
         shadow_q[2] <= '0;
         A           <= '0;
         B           <= '0;
         C           <= '0;
         D           <= '0;
         frame_cnt   <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state_q     <= state_d;
         Sel         <= sel_d;
         shadow_q[0] <= shadow_d[0];
         shadow_q[1] <= shadow_d[1];
         shadow_q[2] <= shadow_d[2];
         A           <= a_d;
         B           <= b_d;
         C           <= c_d;
         D           <= d_d;
         frame_cnt   <= cnt_d;
         frame_valid <= fv_d;
         sync_err    <= se_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = Sel;
      shadow_d[0] = shadow_q[0];
      shadow_d[1] = shadow_q[1];
      shadow_d[2] = shadow_q[2];
      a_d         = A;
      b_d         = B;
      c_d         = C;
      d_d         = D;
      cnt_d       = frame_cnt;
      fv_d        = 1'b0;
      se_d        = 1'b0;

      if (in_valid) begin
         case (state_q)
            IDLE: begin
               // Beats without frame_start while idle carry no slot position: drop them.
               if (frame_start) begin
                  shadow_d[0] = IN;
                  sel_d       = 2'd1;
                  state_d     = RECV;
               end
            end
            RECV: begin
               if (frame_start) begin
                  // Resynchronise: the partial frame is abandoned, this beat is slot 0.
                  se_d        = 1'b1;
                  shadow_d[0] = IN;
                  sel_d       = 2'd1;
               end else begin
                  case (Sel)
                     2'd1: begin
                        shadow_d[1] = IN;
                        sel_d       = 2'd2;
                     end
                     2'd2: begin
                        shadow_d[2] = IN;
                        sel_d       = 2'd3;
                     end
                     2'd3: begin
                        // Publish all four channels on one edge so A..D never mix frames.
                        a_d     = shadow_q[0];
                        b_d     = shadow_q[1];
                        c_d     = shadow_q[2];
                        d_d     = IN;
                        cnt_d   = frame_cnt + CNT_W'(1);
                        fv_d    = 1'b1;
                        sel_d   = 2'd0;
                        state_d = IDLE;
                     end
                     default: begin
                        sel_d = Sel;
                     end
                  endcase
               end
            end
            default: begin
               state_d = IDLE;
               sel_d   = 2'd0;
            end
         endcase
      end
   end

   a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(frame_valid && sync_err));

   a_sel_zero_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == IDLE) |-> (Sel == 2'd0));

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: a frame-level model (list of beats in the current partial frame)
// is checked against the DUT every cycle, plus literal checks from the directed cases.
module tb_tdm_demux4;

   logic       clk;
   logic       rst_n;
   logic [3:0] din;
   logic       in_valid;
   logic       frame_start;
   logic [3:0] a, b, c, d;
   logic [1:0] sel;
   logic       frame_valid;
   logic       sync_err;
   logic [7:0] frame_cnt;
   logic       state_dbg;

   int n_cmp = 0;
   int n_err = 0;
   bit check_en = 0;

   tdm_demux4 #(.WIDTH(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .IN          (din),
      .in_valid    (in_valid),
      .frame_start (frame_start),
      .A           (a),
      .B           (b),
      .C           (c),
      .D           (d),
      .Sel         (sel),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .frame_cnt   (frame_cnt),
      .state_dbg   (state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: the beats of the frame in progress, plus what was last published
   logic [3:0] part_q[$];
   logic [3:0] exp_q[$];
   logic [3:0] exp_a = 0, exp_b = 0, exp_c = 0, exp_d = 0;
   logic [7:0] exp_cnt = 0;
   logic [1:0] exp_sel = 0;
   logic       exp_fv = 0, exp_se = 0;

   always @(posedge clk) begin
      exp_fv = 1'b0;
      exp_se = 1'b0;
      if (!rst_n) begin
         part_q.delete();
         exp_a = 0; exp_b = 0; exp_c = 0; exp_d = 0;
         exp_cnt = 0;
      end else if (in_valid) begin
         if (frame_start) begin
            if (part_q.size() != 0) exp_se = 1'b1;
            part_q.delete();
            part_q.push_back(din);
         end else if (part_q.size() != 0) begin
            part_q.push_back(din);
            if (part_q.size() == 4) begin
               exp_q = part_q;
               exp_a = exp_q[0]; exp_b = exp_q[1]; exp_c = exp_q[2]; exp_d = exp_q[3];
               exp_cnt = exp_cnt + 8'd1;
               exp_fv = 1'b1;
               part_q.delete();
            end
         end
      end
      exp_sel = 2'(part_q.size());
   end

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // scoreboard compare, every cycle once reset has been applied
   always @(negedge clk) begin
      if (check_en) begin
         check("A", 32'(a), 32'(exp_a));
         check("B", 32'(b), 32'(exp_b));
         check("C", 32'(c), 32'(exp_c));
         check("D", 32'(d), 32'(exp_d));
         check("Sel", 32'(sel), 32'(exp_sel));
         check("frame_valid", 32'(frame_valid), 32'(exp_fv));
         check("sync_err", 32'(sync_err), 32'(exp_se));
         check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      end
   end

   // driver tasks
   task automatic beat(input logic fs, input logic [3:0] v);
      @(negedge clk);
      in_valid = 1'b1;
      frame_start = fs;
      din = v;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         frame_start = 1'b0;
         din = 4'(($urandom_range(0, 15)));
      end
   endtask

   task automatic lit_abcd(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [3:0] ec, input logic [3:0] ed);
      check({tag, ".A"}, 32'(a), 32'(ea));
      check({tag, ".B"}, 32'(b), 32'(eb));
      check({tag, ".C"}, 32'(c), 32'(ec));
      check({tag, ".D"}, 32'(d), 32'(ed));
   endtask

   logic [3:0] vals [0:3];

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      frame_start = 1'b0;
      din = 4'd0;
      repeat (2) @(negedge clk);
      check_en = 1;
      lit_abcd("reset", 4'h0, 4'h0, 4'h0, 4'h0);
      check("reset.Sel", 32'(sel), 32'd0);
      check("reset.frame_cnt", 32'(frame_cnt), 32'd0);
      rst_n = 1'b1;

      // 1: contiguous frame 5,6,7,8
      beat(1, 4'h5); beat(0, 4'h6); beat(0, 4'h7); beat(0, 4'h8);
      gap(1);
      lit_abcd("t1", 4'h5, 4'h6, 4'h7, 4'h8);
      check("t1.frame_valid", 32'(frame_valid), 32'd1);
      check("t1.frame_cnt", 32'(frame_cnt), 32'd1);
      gap(1);
      check("t1.frame_valid_drop", 32'(frame_valid), 32'd0);

      // 2: same frame with idle gaps; Sel advances only on beats
      vals[0] = 4'h5; vals[1] = 4'h6; vals[2] = 4'h7; vals[3] = 4'h8;
      for (int i = 0; i < 4; i++) begin
         beat(i == 0, vals[i]);
         gap(1);
         check("t2.Sel", 32'(sel), 32'((i + 1) % 4));
         gap($urandom_range(0, 2));
         check("t2.Sel_hold", 32'(sel), 32'((i + 1) % 4));
      end
      lit_abcd("t2", 4'h5, 4'h6, 4'h7, 4'h8);
      check("t2.frame_cnt", 32'(frame_cnt), 32'd2);

      // 3: frame 1..4, partial 5,6, then resync on 9 followed by A,B,C
      beat(1, 4'h1); beat(0, 4'h2); beat(0, 4'h3); beat(0, 4'h4);
      beat(1, 4'h5); beat(0, 4'h6); beat(1, 4'h9);
      gap(1);
      check("t3.sync_err", 32'(sync_err), 32'd1);
      check("t3.Sel", 32'(sel), 32'd1);
      lit_abcd("t3.hold", 4'h1, 4'h2, 4'h3, 4'h4);
      beat(0, 4'hA); beat(0, 4'hB);
      gap(1);
      lit_abcd("t3.still", 4'h1, 4'h2, 4'h3, 4'h4);
      beat(0, 4'hC);
      gap(1);
      lit_abcd("t3.new", 4'h9, 4'hA, 4'hB, 4'hC);
      check("t3.frame_cnt", 32'(frame_cnt), 32'd4);

      // 4: stray beats while idle are dropped silently
      beat(0, 4'h3); beat(0, 4'h3);
      gap(1);
      check("t4.Sel", 32'(sel), 32'd0);
      check("t4.sync_err", 32'(sync_err), 32'd0);
      beat(1, 4'hF); beat(0, 4'hE); beat(0, 4'hD); beat(0, 4'hC);
      gap(1);
      lit_abcd("t4", 4'hF, 4'hE, 4'hD, 4'hC);

      // 5: reset mid-frame after slot 2
      beat(1, 4'h2); beat(0, 4'h4); beat(0, 4'h6);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      lit_abcd("t5.reset", 4'h0, 4'h0, 4'h0, 4'h0);
      check("t5.Sel", 32'(sel), 32'd0);
      check("t5.frame_cnt0", 32'(frame_cnt), 32'd0);
      beat(1, 4'h7); beat(0, 4'h1); beat(0, 4'h3); beat(0, 4'h5);
      gap(1);
      lit_abcd("t5", 4'h7, 4'h1, 4'h3, 4'h5);
      check("t5.frame_cnt", 32'(frame_cnt), 32'd1);

      // 6: 256 back-to-back frames after a reset -> counter wraps to 0
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int f = 0; f < 256; f++) begin
         for (int s = 0; s < 4; s++) beat(s == 0, 4'($urandom_range(0, 15)));
      end
      gap(1);
      check("t6.frame_valid", 32'(frame_valid), 32'd1);
      check("t6.frame_cnt_wrap", 32'(frame_cnt), 32'd0);
      gap(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
